// File: rtl/restoring_divider_nbit_if.sv
// Start/done handshake and operand/result bundle for the restoring divider.
// The master side issues a division; the slave side returns the registered results.
interface restoring_divider_nbit_if #(
  parameter int SIZE = 16
) ();
  logic            start;
  logic [SIZE-1:0] dividend;
  logic [SIZE-1:0] divisor;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;
  logic            div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider_nbit.sv
// Iterative unsigned restoring divider: one quotient bit per clock, SIZE+1 cycle latency.
// A start is accepted only in IDLE or DONE; a start during CALC is dropped.
module adder_nbit #(
  parameter int SIZE = 17
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            carry_in,
  output logic [SIZE-1:0] sum,
  output logic            carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, carry_in};
endmodule

module restoring_divider_nbit #(
  parameter int SIZE = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  restoring_divider_nbit_if.slave bus
);
  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [SIZE:0]   p_q, p_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] quot_q, quot_d;
  logic [SIZE-1:0] rem_q, rem_d;
  logic            dbz_q, dbz_d;

  logic [SIZE:0]   p_shift;
  logic [SIZE:0]   diff;
  logic            no_borrow;
  logic            p_msb_unused;

  // The partial remainder never exceeds the divisor, so its top bit only matters inside the trial subtraction.
  assign p_shift      = {p_q[SIZE-1:0], q_q[SIZE-1]};
  assign p_msb_unused = p_q[SIZE];

  adder_nbit #(.SIZE(SIZE + 1)) u_trial_sub (
    .a         (p_shift),
    .b         (~{1'b0, dvs_q}),
    .carry_in  (1'b1),
    .sum       (diff),
    .carry_out (no_borrow)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            q_d     = bus.dividend;
            dvs_d   = bus.divisor;
            p_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        p_d   = no_borrow ? diff : p_shift;
        q_d   = {q_q[SIZE-2:0], no_borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SIZE - 1)) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = p_d[SIZE-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
